morse_decoder: RTL and testbench

MORSE_DECODER -- requirements
Module: morse_decoder

---
 rtl/morse_decoder.sv | 122 ++++++++++++
 tb/tb_morse_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// ============================================================================
//  Module   : morse_decoder
//  Brief    : Decodes 14-slot on/off light frames into one of eight letters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module morse_decoder (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tick,
    input  logic       light,
    output logic [2:0] letter,
    output logic       valid,
    output logic       error,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_CHECK   = 2'd2
    } state_t;

    localparam logic [3:0]  c_frame_len = 4'd13;

    localparam logic [12:0] c_pat_j = 13'b1011101110111;
    localparam logic [12:0] c_pat_k = 13'b1110101110000;
    localparam logic [12:0] c_pat_l = 13'b1011101010000;
    localparam logic [12:0] c_pat_m = 13'b1110111000000;
    localparam logic [12:0] c_pat_n = 13'b1110100000000;
    localparam logic [12:0] c_pat_o = 13'b1110111011100;
    localparam logic [12:0] c_pat_p = 13'b1011101110100;
    localparam logic [12:0] c_pat_q = 13'b1110111010111;

    state_t      state_q;
    logic [12:0] payload_q;
    logic [3:0]  count_q;
    logic [2:0]  letter_q;
    logic        valid_q;
    logic        error_q;
    logic        busy_q;

    logic        match_d;
    logic [2:0]  code_d;

    always_comb begin
        match_d = 1'b1;
        code_d  = 3'd0;
        case (payload_q)
            c_pat_j: code_d = 3'd0;
            c_pat_k: code_d = 3'd1;
            c_pat_l: code_d = 3'd2;
            c_pat_m: code_d = 3'd3;
            c_pat_n: code_d = 3'd4;
            c_pat_o: code_d = 3'd5;
            c_pat_p: code_d = 3'd6;
            c_pat_q: code_d = 3'd7;
            default: match_d = 1'b0;
        endcase
    end

    // A full frame spends one extra cycle in CAPTURE with count=13 before
    // CHECK, giving a fixed two-cycle latency from the last sample to the pulse.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            payload_q <= 13'd0;
            count_q   <= 4'd0;
            letter_q  <= 3'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Ticks during the result pulse cycle must not start a frame.
                    if (tick && light && !valid_q && !error_q) begin
                        payload_q <= 13'd1;
                        count_q   <= 4'd1;
                        state_q   <= S_CAPTURE;
                        busy_q    <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (count_q == c_frame_len) begin
                        state_q <= S_CHECK;
                    end else if (tick) begin
                        payload_q <= {payload_q[11:0], light};
                        count_q   <= count_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    count_q <= 4'd0;
                    if (match_d) begin
                        letter_q <= code_d;
                        valid_q  <= 1'b1;
                    end else begin
                        error_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    count_q <= 4'd0;
                end
            endcase
        end
    end

    assign letter = letter_q;
    assign valid  = valid_q;
    assign error  = error_q;
    assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_morse_decoder.sv
// Self-checking bench for morse_decoder: frame table plus hand-built corner sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_morse_decoder;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       tick   = 1'b0;
    logic       light  = 1'b0;
    logic [2:0] letter;
    logic       valid;
    logic       error;
    logic       busy;

    morse_decoder dut (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick),
        .light  (light),
        .letter (letter),
        .valid  (valid),
        .error  (error),
        .busy   (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] letter;
        logic       err;
    } exp_t;

    typedef struct {
        logic [12:0] payload;
        logic [2:0]  letter;
        logic        err;
    } vec_t;

    exp_t       sb[$];
    int         checks         = 0;
    int         errors         = 0;
    int         cyc            = 0;
    int         pulses         = 0;
    int         last_pulse_cyc = -1;
    logic [2:0] model_letter   = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock; outputs sampled 1 ns after the rising edge and any pulse popped.
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        if (valid && error) begin
            checks++;
            errors++;
            $display("FAIL valid_and_error: both high at cycle %0d, required exclusive", cyc);
        end
        if (valid || error) begin
            pulses++;
            last_pulse_cyc = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b error=%0b letter=%0d, required no pulse", valid, error, letter);
            end else begin
                e = sb.pop_front();
                chk("pulse_is_error", {31'd0, error}, {31'd0, e.err});
                chk("pulse_is_valid", {31'd0, valid}, {31'd0, ~e.err});
                chk("pulse_letter", {29'd0, letter}, {29'd0, e.letter});
            end
        end
    endtask

    task automatic slot(input logic b, input int period);
        tick  = 1'b1;
        light = b;
        step();
        tick  = 1'b0;
        light = 1'b0;
        repeat (period - 1) step();
    endtask

    // Leading 0 slot then payload bits 12..0; expectation queued before the 13th tick.
    task automatic send_frame(input logic [12:0] p, input int period,
                              input logic [2:0] exp_letter, input logic exp_err,
                              output int t13);
        exp_t e;
        t13 = -1;
        slot(1'b0, period);
        for (int i = 12; i >= 0; i--) begin
            if (i == 0) begin
                if (!exp_err) model_letter = exp_letter;
                e.letter = model_letter;
                e.err    = exp_err;
                sb.push_back(e);
            end
            tick  = 1'b1;
            light = p[i];
            step();
            if (i == 0) t13 = cyc;
            tick  = 1'b0;
            light = 1'b0;
            repeat (period - 1) step();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[10];
        int         t13;
        int         p0;
        logic [12:0] jpat;

        tbl[0] = '{13'b1011101110111, 3'd0, 1'b0};
        tbl[1] = '{13'b1110101110000, 3'd1, 1'b0};
        tbl[2] = '{13'b1011101010000, 3'd2, 1'b0};
        tbl[3] = '{13'b1110111000000, 3'd3, 1'b0};
        tbl[4] = '{13'b1110100000000, 3'd4, 1'b0};
        tbl[5] = '{13'b1110111011100, 3'd5, 1'b0};
        tbl[6] = '{13'b1011101110100, 3'd6, 1'b0};
        tbl[7] = '{13'b1110111010111, 3'd7, 1'b0};
        tbl[8] = '{13'b1111111111111, 3'd0, 1'b1};
        tbl[9] = '{13'b1110111000001, 3'd0, 1'b1};

        // Reset state
        resetn = 1'b0;
        repeat (3) step();
        chk("reset_letter", {29'd0, letter}, 32'd0);
        chk("reset_valid",  {31'd0, valid},  32'd0);
        chk("reset_error",  {31'd0, error},  32'd0);
        chk("reset_busy",   {31'd0, busy},   32'd0);
        resetn = 1'b1;
        step();

        // Only dark ticks: must stay idle
        p0 = pulses;
        for (int i = 0; i < 50; i++) begin
            slot(1'b0, 1);
            chk("dark_busy", {31'd0, busy}, 32'd0);
        end
        chk("dark_no_pulse", pulses - p0, 32'd0);

        // Single M frame, one tick every 4 clocks
        p0 = pulses;
        send_frame(13'b1110111000000, 4, 3'd3, 1'b0, t13);
        repeat (6) step();
        chk("m_pulse_count", pulses - p0, 32'd1);
        chk("m_latency", last_pulse_cyc - t13, 32'd2);
        chk("m_letter_held", {29'd0, letter}, 32'd3);
        chk("m_busy_after", {31'd0, busy}, 32'd0);

        // All letters back to back, then two unmatched patterns
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].payload, 4, tbl[i].letter, tbl[i].err, t13);
        end
        repeat (8) step();
        chk("table_pulse_count", pulses - p0, 32'd10);
        chk("table_letter_after_errors", {29'd0, letter}, 32'd7);

        // Reset mid-frame abandons J; K afterwards decodes normally
        p0   = pulses;
        jpat = 13'b1011101110111;
        slot(1'b0, 4);
        for (int i = 12; i >= 7; i--) slot(jpat[i], 4);
        chk("abort_busy_before_reset", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        model_letter = 3'd0;
        chk("abort_busy_after_reset", {31'd0, busy}, 32'd0);
        chk("abort_letter_after_reset", {29'd0, letter}, 32'd0);
        send_frame(13'b1110101110000, 4, 3'd1, 1'b0, t13);
        repeat (8) step();
        chk("abort_pulse_count", pulses - p0, 32'd1);
        chk("abort_k_letter", {29'd0, letter}, 32'd1);

        // Max rate Q with tick still high through CHECK and the pulse cycle
        p0 = pulses;
        send_frame(13'b1110111010111, 1, 3'd7, 1'b0, t13);
        tick  = 1'b1;
        light = 1'b1;
        step();
        chk("maxrate_busy_full", {31'd0, busy}, 32'd1);
        chk("maxrate_valid_early", {31'd0, valid}, 32'd0);
        step();
        chk("maxrate_latency", last_pulse_cyc - t13, 32'd2);
        chk("maxrate_letter", {29'd0, letter}, 32'd7);
        step();
        chk("maxrate_tick_in_pulse_ignored", {31'd0, busy}, 32'd0);
        tick  = 1'b0;
        light = 1'b0;
        step();
        chk("maxrate_busy_idle", {31'd0, busy}, 32'd0);
        repeat (4) step();
        chk("maxrate_pulse_count", pulses - p0, 32'd1);

        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
